// File: rtl/toggle_bank_pkg.sv
// Shared types and the lane update function for toggle_bank and its checker.
package toggle_bank_pkg;

  // Widest lane vector the shared helper handles; WIDTH must not exceed it.
  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    MODE_COPY   = 2'd0,
    MODE_TOGGLE = 2'd1,
    MODE_INVERT = 2'd2,
    MODE_HOLD   = 2'd3
  } mode_e;

  // Next core state for one enabled cycle. Vectors are zero-extended to MAX_W
  // by the caller and truncated back to the lane width afterwards.
  function automatic logic [MAX_W-1:0] next_state(
    input mode_e            m,
    input logic [MAX_W-1:0] s,
    input logic [MAX_W-1:0] q
  );
    logic [MAX_W-1:0] r;
    case (m)
      MODE_COPY:   r = q;
      MODE_TOGGLE: r = s ^ q;
      MODE_INVERT: r = ~q;
      MODE_HOLD:   r = s;
      default:     r = s;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/toggle_bank_checker.sv
// Assertion-only observer of toggle_bank: lane functions, output latency,
// change counter monotonicity/saturation and the values held during reset.
module toggle_bank_checker
  import toggle_bank_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input logic             clk,
  input logic             reset,
  input logic             en,
  input logic [1:0]       mode,
  input logic [WIDTH-1:0] q,
  input logic [WIDTH-1:0] s,
  input logic [WIDTH-1:0] z,
  input logic             z_valid,
  input logic [CNT_W-1:0] chg_cnt,
  input logic             chg_sat
);

  // Edges seen since reset release; history-based checks wait until $past
  // no longer reaches back into the reset period.
  logic [31:0] edges_r;
  logic        ready1_s;
  logic        ready_lat_s;
  logic [WIDTH-1:0] exp_next_s;

  assign ready1_s    = (edges_r >= 32'd1);
  assign ready_lat_s = (edges_r >= 32'(LATENCY));
  assign exp_next_s  = WIDTH'(next_state(mode_e'(mode), MAX_W'(s), MAX_W'(q)));

  // Count post-reset edges, saturating once the deepest history is covered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edges_r <= 32'd0;
    end else if (edges_r < 32'(LATENCY)) begin
      edges_r <= edges_r + 32'd1;
    end else begin
      edges_r <= edges_r;
    end
  end

  a_copy: assert property (@(posedge clk) disable iff (reset)
    (ready1_s && $past(en) && mode_e'($past(mode)) == MODE_COPY) |-> (s == $past(q)))
    else $error("toggle_bank_checker: copy next state");

  a_toggle: assert property (@(posedge clk) disable iff (reset)
    (ready1_s && $past(en) && mode_e'($past(mode)) == MODE_TOGGLE) |-> (s == ($past(s) ^ $past(q))))
    else $error("toggle_bank_checker: toggle next state");

  a_invert: assert property (@(posedge clk) disable iff (reset)
    (ready1_s && $past(en) && mode_e'($past(mode)) == MODE_INVERT) |-> (s == ~$past(q)))
    else $error("toggle_bank_checker: invert next state");

  a_hold: assert property (@(posedge clk) disable iff (reset)
    (ready1_s && (!$past(en) || mode_e'($past(mode)) == MODE_HOLD)) |-> (s == $past(s)))
    else $error("toggle_bank_checker: hold or disabled state");

  a_next_fn: assert property (@(posedge clk) disable iff (reset)
    (ready1_s && $past(en)) |-> (s == $past(exp_next_s)))
    else $error("toggle_bank_checker: shared next_state mismatch");

  a_valid_lat: assert property (@(posedge clk) disable iff (reset)
    ready_lat_s |-> (z_valid == $past(en, LATENCY)))
    else $error("toggle_bank_checker: z_valid latency");

  a_copy_lat: assert property (@(posedge clk) disable iff (reset)
    (ready_lat_s && $past(en, LATENCY) && mode_e'($past(mode, LATENCY)) == MODE_COPY)
      |-> (z == $past(q, LATENCY)))
    else $error("toggle_bank_checker: copy data latency");

  a_cnt_mono: assert property (@(posedge clk) disable iff (reset)
    ready1_s |-> (chg_cnt >= $past(chg_cnt)))
    else $error("toggle_bank_checker: counter decreased");

  a_sat_flag: assert property (@(posedge clk) disable iff (reset)
    chg_sat == (chg_cnt == {CNT_W{1'b1}}))
    else $error("toggle_bank_checker: saturation flag");

  a_sat_sticky: assert property (@(posedge clk) disable iff (reset)
    (ready1_s && $past(chg_sat)) |-> chg_sat)
    else $error("toggle_bank_checker: saturation released");

  a_reset_vals: assert property (@(posedge clk)
    reset |-> (z == {WIDTH{1'b0}} && !z_valid && chg_cnt == {CNT_W{1'b0}} && !chg_sat))
    else $error("toggle_bank_checker: values under reset");

endmodule

// File: rtl/toggle_bank.sv
// WIDTH-lane bank of toggle cells: per-cycle copy/toggle/invert/hold update,
// LATENCY-cycle output pipeline and a saturating output-change counter.
module toggle_bank
  import toggle_bank_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] z,
  output logic             z_valid,
  output logic [CNT_W-1:0] chg_cnt,
  output logic             chg_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] s_r;
  logic [WIDTH-1:0] s_next_s;
  logic             en_r;
  logic [WIDTH-1:0] pipe_z_s;
  logic             pipe_valid_s;
  logic [WIDTH-1:0] z_prev_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             sat_r;

  // Next core state: apply the selected lane function on enabled cycles only.
  always_comb begin
    s_next_s = s_r;
    if (en) begin
      s_next_s = WIDTH'(next_state(mode_e'(mode), MAX_W'(s_r), MAX_W'(q)));
    end else begin
      s_next_s = s_r;
    end
  end

  // Core state and the registered enable that tags it as a valid update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_r  <= {WIDTH{1'b0}};
      en_r <= 1'b0;
    end else begin
      s_r  <= s_next_s;
      en_r <= en;
    end
  end

  generate
    if (LATENCY > 1) begin : g_pipe
      logic [WIDTH-1:0] data_r  [LATENCY-1];
      logic             valid_r [LATENCY-1];

      // Free-running delay line; shifts every cycle regardless of en.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < LATENCY - 1; i++) begin
            data_r[i]  <= {WIDTH{1'b0}};
            valid_r[i] <= 1'b0;
          end
        end else begin
          data_r[0]  <= s_r;
          valid_r[0] <= en_r;
          for (int i = 1; i < LATENCY - 1; i++) begin
            data_r[i]  <= data_r[i-1];
            valid_r[i] <= valid_r[i-1];
          end
        end
      end

      assign pipe_z_s     = data_r[LATENCY-2];
      assign pipe_valid_s = valid_r[LATENCY-2];
    end else begin : g_direct
      assign pipe_z_s     = s_r;
      assign pipe_valid_s = en_r;
    end
  endgenerate

  // Count a change whenever z differs from last cycle's z, stopping at all ones.
  always_comb begin
    cnt_next_s = cnt_r;
    if ((z_prev_r != pipe_z_s) && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_W'(1'b1);
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Previous-z snapshot, change counter and its registered saturation flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      z_prev_r <= {WIDTH{1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      sat_r    <= 1'b0;
    end else begin
      z_prev_r <= pipe_z_s;
      cnt_r    <= cnt_next_s;
      sat_r    <= (cnt_next_s == CNT_MAX);
    end
  end

  assign z       = pipe_z_s;
  assign z_valid = pipe_valid_s;
  assign chg_cnt = cnt_r;
  assign chg_sat = sat_r;

  toggle_bank_checker #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY),
    .CNT_W   (CNT_W)
  ) u_checker (
    .clk     (clk),
    .reset   (reset),
    .en      (en),
    .mode    (mode),
    .q       (q),
    .s       (s_r),
    .z       (pipe_z_s),
    .z_valid (pipe_valid_s),
    .chg_cnt (cnt_r),
    .chg_sat (sat_r)
  );

endmodule

// File: tb/tb_toggle_bank.sv
// Bench for toggle_bank: two instances (LATENCY=3/CNT_W=8 and LATENCY=1/CNT_W=2)
// share one stimulus stream and are compared every cycle against a history-based
// model, plus directed spot checks for the documented scenarios.
module tb_toggle_bank;

  localparam int LAT_A  = 3;
  localparam int LAT_B  = 1;
  localparam int CMAX_A = 255;
  localparam int CMAX_B = 3;

  logic       clk;
  logic       reset;
  logic       en;
  logic [1:0] mode;
  logic [7:0] q;

  logic [7:0] z_a;
  logic       zv_a;
  logic [7:0] cnt_a;
  logic       sat_a;
  logic [7:0] z_b;
  logic       zv_b;
  logic [1:0] cnt_b;
  logic       sat_b;

  int n_chk;
  int n_err;

  // Model: history of the lane state after each edge (index 0 = newest) and
  // the enable that produced it; z of a LATENCY=L block is entry L-1.
  logic [7:0] hs [0:7];
  logic       hv [0:7];
  logic [7:0] zb_a, zpb_a, zb_b, zpb_b;
  int         mcnt_a, mcnt_b;

  toggle_bank #(.WIDTH(8), .LATENCY(LAT_A), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .q(q),
    .z(z_a), .z_valid(zv_a), .chg_cnt(cnt_a), .chg_sat(sat_a)
  );

  toggle_bank #(.WIDTH(8), .LATENCY(LAT_B), .CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .q(q),
    .z(z_b), .z_valid(zv_b), .chg_cnt(cnt_b), .chg_sat(sat_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      hs[i] = 8'h00;
      hv[i] = 1'b0;
    end
    zb_a = 8'h00; zpb_a = 8'h00; zb_b = 8'h00; zpb_b = 8'h00;
    mcnt_a = 0; mcnt_b = 0;
  endtask

  task automatic model_edge();
    logic [7:0] s_new;
    if (zb_a != zpb_a && mcnt_a < CMAX_A) mcnt_a++;
    if (zb_b != zpb_b && mcnt_b < CMAX_B) mcnt_b++;
    zpb_a = zb_a;
    zpb_b = zb_b;
    if (en) begin
      case (mode)
        2'd0:    s_new = q;
        2'd1:    s_new = hs[0] ^ q;
        2'd2:    s_new = ~q;
        default: s_new = hs[0];
      endcase
    end else begin
      s_new = hs[0];
    end
    for (int i = 7; i > 0; i--) begin
      hs[i] = hs[i-1];
      hv[i] = hv[i-1];
    end
    hs[0] = s_new;
    hv[0] = en;
    zb_a = hs[LAT_A-1];
    zb_b = hs[LAT_B-1];
  endtask

  task automatic compare_all();
    check("a_z",     32'(z_a),   32'(hs[LAT_A-1]));
    check("a_valid", 32'(zv_a),  32'(hv[LAT_A-1]));
    check("a_cnt",   32'(cnt_a), 32'(mcnt_a));
    check("a_sat",   32'(sat_a), 32'(mcnt_a == CMAX_A));
    check("b_z",     32'(z_b),   32'(hs[LAT_B-1]));
    check("b_valid", 32'(zv_b),  32'(hv[LAT_B-1]));
    check("b_cnt",   32'(cnt_b), 32'(mcnt_b));
    check("b_sat",   32'(sat_b), 32'(mcnt_b == CMAX_B));
  endtask

  // One clock: drive on the falling edge, update the model on the rising edge,
  // compare 1 time unit later. A reset step also checks the asynchronous clear.
  task automatic step(input logic e, input logic [1:0] m, input logic [7:0] d, input logic r);
    @(negedge clk);
    en = e; mode = m; q = d; reset = r;
    if (r) begin
      #1;
      check("rst_async_z_a",   32'(z_a),   32'd0);
      check("rst_async_v_a",   32'(zv_a),  32'd0);
      check("rst_async_cnt_a", 32'(cnt_a), 32'd0);
      check("rst_async_sat_b", 32'(sat_b), 32'd0);
    end
    @(posedge clk);
    if (r) model_reset();
    else   model_edge();
    #1;
    compare_all();
  endtask

  initial begin
    logic [7:0] cnt_keep;
    n_chk = 0; n_err = 0;
    reset = 1'b1; en = 1'b0; mode = 2'd0; q = 8'h00;
    model_reset();

    // Reset state
    step(1'b0, 2'd0, 8'h00, 1'b1);
    step(1'b0, 2'd0, 8'h00, 1'b1);

    // Copy latency: 3C appears exactly on the third edge, valid for one cycle
    step(1'b1, 2'd0, 8'h3C, 1'b0);
    step(1'b0, 2'd0, 8'h11, 1'b0);
    step(1'b0, 2'd0, 8'h22, 1'b0);
    check("copy_lat_z", 32'(z_a), 32'h3C);
    check("copy_lat_valid", 32'(zv_a), 32'd1);
    step(1'b0, 2'd0, 8'h33, 1'b0);
    check("copy_valid_once", 32'(zv_a), 32'd0);

    // Reset mid-stream: A5 in flight is lost
    step(1'b1, 2'd0, 8'hA5, 1'b0);
    step(1'b1, 2'd0, 8'hA5, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 2'd0, 8'h00, 1'b0);
      check("no_a5_after_reset", 32'(z_a == 8'hA5), 32'd0);
    end

    // Toggle composition from s=0
    step(1'b1, 2'd1, 8'h0F, 1'b0);
    step(1'b1, 2'd1, 8'h0F, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    check("toggle_first", 32'(z_a), 32'h0F);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    check("toggle_second", 32'(z_a), 32'h00);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    check("toggle_cnt", 32'(cnt_a), 32'd2);

    // Invert then hold
    step(1'b1, 2'd2, 8'hF0, 1'b0);
    step(1'b1, 2'd3, 8'hFF, 1'b0);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    check("invert_z", 32'(z_a), 32'h0F);
    step(1'b0, 2'd0, 8'h00, 1'b0);
    check("hold_z", 32'(z_a), 32'h0F);
    check("hold_valid", 32'(zv_a), 32'd1);
    cnt_keep = cnt_a;
    step(1'b0, 2'd0, 8'h00, 1'b0);
    check("hold_no_count", 32'(cnt_a), 32'(cnt_keep));

    // en low with random q/mode after loading 55
    step(1'b1, 2'd0, 8'h55, 1'b0);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 2'($urandom_range(0, 3)), 8'($urandom), 1'b0);
      if (i >= 1) check("en_low_z", 32'(z_a), 32'h55);
      if (i >= 2) check("en_low_valid", 32'(zv_a), 32'd0);
    end

    // Saturation on the CNT_W=2, LATENCY=1 instance
    step(1'b0, 2'd0, 8'h00, 1'b1);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd1, 8'h01, 1'b0);
      if (i >= 3) begin
        check("sat_cnt", 32'(cnt_b), 32'd3);
        check("sat_flag", 32'(sat_b), 32'd1);
      end
    end

    // Random traffic with occasional reset
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom),
           1'($urandom_range(0, 39) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/toggle_bank.md
# toggle_bank

Parametrised, multi-bit successor to the single-bit toggle cell used in the SimpleCircuit formal experiments. Each of WIDTH independent bit lanes is updated on enabled cycles according to a run-time mode: copy, toggle, invert or hold. The result is delayed through a configurable output pipeline, and a saturating change counter reports output activity. The block is the next target for the bound-assertion flow: its checker covers latency, modes and the counter.

## Interface
Parameters:
- WIDTH, 8, number of independent bit lanes (≥1)
- LATENCY, 1, cycles from an enabled input sample to its appearance on z (≥1); with LATENCY=1 and copy mode the block matches the single-bit toggle cell
- CNT_W, 8, width of the change counter (≥2)

Ports:
- clk  input  1  rising-edge clock; the only clock
- reset  input  1  asynchronous, active-high; clears all state immediately
- en  input  1  update enable; the input sample is taken when en=1 on a rising edge
- mode  input  2  update function: 0 copy, 1 toggle, 2 invert, 3 hold
- q  input  WIDTH  lane data / toggle mask
- z  output  WIDTH  delayed lane state
- z_valid  output  1  high when z reflects an enabled update made exactly LATENCY cycles earlier
- chg_cnt  output  CNT_W  number of cycles in which z changed, saturating
- chg_sat  output  1  high while chg_cnt equals its maximum value

## Operation
- Core state register s[WIDTH-1:0]. On a rising edge with en=1:
  - copy: s←q
  - toggle: s←s^q
  - invert: s←~q
  - hold: s unchanged, but the cycle still counts as a valid update
- With en=0, s holds.
- Pipeline: LATENCY-1 delay stages after s, each carrying {data, valid}. All stages shift every cycle, independent of en.
  - The valid bit entering the pipeline is the registered en.
  - z = last-stage data; z_valid = last-stage valid.
  - With LATENCY=1 there are no delay stages: z=s and z_valid=registered en.
- Change counter:
  - Keep a register z_prev holding z from the previous cycle.
  - If z≠z_prev, increment chg_cnt.
  - Saturate at 2^CNT_W−1 and never wrap.
  - chg_sat = (chg_cnt == all ones).
- Reset asserted at any time, including mid-pipeline: s, all stage data and valids, z_prev and chg_cnt go to 0 asynchronously. The effect is z=0, z_valid=0, chg_cnt=0, chg_sat=0.
- Reset deassertion: the first rising edge after deassertion may sample en. Pipeline contents in flight before reset are lost and never emerge.
- Unknown or illegal mode values do not exist; all 2-bit encodings are defined.

## Timing
- Latency: q sampled at edge k with en=1 produces z at edge k+LATENCY−1 (visible after edge k+LATENCY−1), exactly LATENCY cycles after the sample is applied.
  - Checker form: (en && mode==0) |-> ##LATENCY (z == $past(q, LATENCY)) && z_valid.
- Throughput: one update per cycle. Back-to-back enabled toggles compose, e.g. two toggles with mask m return the lane to its original value.
- chg_cnt updates one cycle after z changes, because of the compare against z_prev.
- Reset-to-output is combinational through the flops (asynchronous clear); there are no reset-release synchronisers inside the block.

## Structure
- Package toggle_bank_pkg holds:
  - typedef enum logic [1:0] mode_e {MODE_COPY, MODE_TOGGLE, MODE_INVERT, MODE_HOLD}
  - the function next_state(mode_e, s, q) shared by the RTL and the checker
- Sub-module toggle_bank_checker: assertion-only, bound into toggle_bank. It checks:
  - the per-mode next-state property for each mode
  - latency of z_valid
  - that chg_cnt never decreases
  - saturation
  - the post-reset values, with disable iff (reset) on all sequential properties

## Test plan
- Reset mid-stream: WIDTH=8, LATENCY=3, copy mode, q=8'hA5, en=1 for 2 cycles, then reset pulse → z=0, z_valid=0, chg_cnt=0. 8'hA5 never appears after release.
- Copy latency: LATENCY=3, en=1 one cycle with q=8'h3C → z=8'h3C with z_valid=1 exactly 3 cycles later. z_valid is high for one cycle only.
- Toggle composition: toggle mode, q=8'h0F on two consecutive enabled cycles from s=0 → z shows 8'h0F then 8'h00. chg_cnt increments by 2.
- Invert vs hold: invert with q=8'hF0 gives z=8'h0F. Then hold with en=1 and q=8'hFF keeps z=8'h0F, with z_valid=1 and no chg_cnt increment.
- en low: after loading 8'h55, drive en=0 with q changing randomly for 10 cycles → z stays 8'h55, z_valid=0 after LATENCY cycles.
- Saturation: CNT_W=2, toggle mode, q=8'h01 every cycle for 6 cycles → chg_cnt reaches 3 and stays 3. chg_sat=1 from that cycle on.
